serv_gpio: RTL and testbench

//  Parametrised GPIO peripheral on the SERV dbus; successor of the fixed 3-bit write-only LED latch.

---
 rtl/serv_gpio_pkg.sv | 25 ++
 rtl/serv_gpio_sync.sv | 63 ++++++
 rtl/serv_gpio.sv | 185 ++++++++++++++++++
 tb/tb_serv_gpio.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_gpio_pkg.sv
// Shared definitions for the serv_gpio peripheral: register offsets and the
// byte-enable to bit-mask helper.
package serv_gpio_pkg;

   // Byte offsets within the peripheral window; only address bits [5:2] are decoded.
   localparam logic [5:0] GPIO_OUT        = 6'h00;
   localparam logic [5:0] GPIO_DIR        = 6'h04;
   localparam logic [5:0] GPIO_IN         = 6'h08;
   localparam logic [5:0] GPIO_SET        = 6'h0C;
   localparam logic [5:0] GPIO_CLR        = 6'h10;
   localparam logic [5:0] GPIO_TGL        = 6'h14;
   localparam logic [5:0] GPIO_IRQ_ENABLE = 6'h18;
   localparam logic [5:0] GPIO_IRQ_STAT   = 6'h1C;
   localparam logic [5:0] GPIO_IRQ_EDGE   = 6'h20;

   function automatic logic [31:0] byte_mask(input logic [3:0] sel);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         m[i*8 +: 8] = {8{sel[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/serv_gpio_sync.sv
// Multi-stage pad input synchroniser with optional rise/fall pulse outputs
// (pulses are high for one cycle after the synchronised value changes).
module serv_gpio_sync
   import serv_gpio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE_EN     = 1'b0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

   generate
      if (EDGE_EN) begin : g_edge
         // Compare the synchronised value with its one-cycle-delayed copy.
         logic [WIDTH-1:0] prev_q;
         logic [WIDTH-1:0] prev_d;

         always_comb prev_d = q;

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               prev_q <= '0;
            end else begin
               prev_q <= prev_d;
            end
         end

         assign rise = q & ~prev_q;
         assign fall = ~q & prev_q;
      end else begin : g_no_edge
         assign rise = '0;
         assign fall = '0;
      end
   endgenerate

endmodule

// File: rtl/serv_gpio.sv
// GPIO peripheral on the SERV dbus: OUT/DIR/IN registers, atomic SET/CLR/TGL,
// byte-lane writes. Defining GPIO_IRQ_EN adds edge-triggered interrupt registers.
module serv_gpio
   import serv_gpio_pkg::*;
#(
   parameter int          WIDTH       = 8,
   parameter int          SYNC_STAGES = 2,
   parameter bit          OUT_INVERT  = 1'b0,
   parameter logic [31:0] OUT_RESET   = 32'h0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [31:0]      i_adr,
   input  logic [31:0]      i_dat,
   input  logic [3:0]       i_sel,
   input  logic             i_we,
   input  logic             i_cyc,
   output logic [31:0]      o_rdt,
   output logic             o_ack,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             o_irq
);

`ifdef GPIO_IRQ_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   // Handshake: the master raises i_cyc and holds adr/dat/sel/we until o_ack.
   // o_ack pulses for exactly one cycle, one cycle after i_cyc is seen without
   // a pending ack; all register effects and the read data happen on that edge.
   logic             ack_q, ack_d;
   logic [31:0]      rdt_q, rdt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] dir_q, dir_d;

   logic             access;
   logic             wr;
   logic             rd;
   logic [5:0]       offset;
   logic [31:0]      bmask;
   logic [31:0]      wmask;
   logic [WIDTH-1:0] lane_w;
   logic [WIDTH-1:0] m_w;

   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] in_rise;
   logic [WIDTH-1:0] in_fall;

   function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
      logic [31:0] r;
      r            = '0;
      r[WIDTH-1:0] = v;
      return r;
   endfunction

   serv_gpio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_EN     (EDGE_EN)
   ) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (gpio_i),
      .q      (in_sync),
      .rise   (in_rise),
      .fall   (in_fall)
   );

`ifdef GPIO_IRQ_EN
   logic [WIDTH-1:0] irq_en_q,   irq_en_d;
   logic [WIDTH-1:0] irq_stat_q, irq_stat_d;
   logic [WIDTH-1:0] irq_edge_q, irq_edge_d;
   logic             irq_q,      irq_d;
   logic [WIDTH-1:0] irq_hit;
   logic [WIDTH-1:0] irq_w1c;
`endif

   always_comb begin
      ack_d  = i_cyc && !ack_q;
      access = ack_d;
      wr     = access && i_we;
      rd     = access && !i_we;
      offset = {i_adr[5:2], 2'b00};
      bmask  = byte_mask(i_sel);
      wmask  = i_dat & bmask;
      lane_w = bmask[WIDTH-1:0];
      m_w    = wmask[WIDTH-1:0];
      out_d  = out_q;
      dir_d  = dir_q;
      rdt_d  = '0;

      if (wr) begin
         case (offset)
            GPIO_OUT: out_d = (out_q & ~lane_w) | m_w;
            GPIO_DIR: dir_d = (dir_q & ~lane_w) | m_w;
            GPIO_SET: out_d = out_q | m_w;
            GPIO_CLR: out_d = out_q & ~m_w;
            GPIO_TGL: out_d = out_q ^ m_w;
            default:  ;
         endcase
      end

      if (rd) begin
         case (offset)
            GPIO_OUT:        rdt_d = zext(out_q);
            GPIO_DIR:        rdt_d = zext(dir_q);
            GPIO_IN:         rdt_d = zext(in_sync);
`ifdef GPIO_IRQ_EN
            GPIO_IRQ_ENABLE: rdt_d = zext(irq_en_q);
            GPIO_IRQ_STAT:   rdt_d = zext(irq_stat_q);
            GPIO_IRQ_EDGE:   rdt_d = zext(irq_edge_q);
`endif
            default:         rdt_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ack_q <= 1'b0;
         rdt_q <= '0;
         out_q <= OUT_RESET[WIDTH-1:0];
         dir_q <= '0;
      end else begin
         ack_q <= ack_d;
         rdt_q <= rdt_d;
         out_q <= out_d;
         dir_q <= dir_d;
      end
   end

`ifdef GPIO_IRQ_EN
   // A new edge wins over a same-cycle W1C, so no event is ever lost.
   always_comb begin
      irq_en_d   = irq_en_q;
      irq_edge_d = irq_edge_q;
      irq_w1c    = '0;
      irq_hit    = irq_en_q & ((in_rise & ~irq_edge_q) | (in_fall & irq_edge_q));

      if (wr) begin
         case (offset)
            GPIO_IRQ_ENABLE: irq_en_d   = (irq_en_q & ~lane_w) | m_w;
            GPIO_IRQ_STAT:   irq_w1c    = m_w;
            GPIO_IRQ_EDGE:   irq_edge_d = (irq_edge_q & ~lane_w) | m_w;
            default:         ;
         endcase
      end

      irq_stat_d = (irq_stat_q & ~irq_w1c) | irq_hit;
      irq_d      = |(irq_stat_d & irq_en_d);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         irq_en_q   <= '0;
         irq_stat_q <= '0;
         irq_edge_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         irq_en_q   <= irq_en_d;
         irq_stat_q <= irq_stat_d;
         irq_edge_q <= irq_edge_d;
         irq_q      <= irq_d;
      end
   end

   assign o_irq = irq_q;
`else
   assign o_irq = 1'b0;
`endif

   // Undecoded address bits and lanes above WIDTH are intentionally dropped.
   logic unused_bits;
   assign unused_bits = ^{i_adr[31:6], i_adr[1:0], bmask, wmask, in_rise, in_fall};

   assign gpio_o  = out_q ^ {WIDTH{OUT_INVERT}};
   assign gpio_oe = dir_q;
   assign o_ack   = ack_q;
   assign o_rdt   = rdt_q;

endmodule

// File: tb/tb_serv_gpio.sv
// Bench for serv_gpio: per-cycle reference model plus directed register tests.
// Compile with +define+GPIO_IRQ_EN to also cover the interrupt registers.
module tb_serv_gpio;

   localparam int W  = 8;
   localparam int SS = 2;
   localparam logic [7:0] OUT_RST = 8'hA5;

   logic          clk = 1'b0;
   logic          resetn;
   logic [31:0]   i_adr;
   logic [31:0]   i_dat;
   logic [3:0]    i_sel;
   logic          i_we;
   logic          i_cyc;
   logic [31:0]   o_rdt;
   logic          o_ack;
   logic [W-1:0]  gpio_i;
   logic [W-1:0]  gpio_o;
   logic [W-1:0]  gpio_oe;
   logic          o_irq;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   serv_gpio #(
      .WIDTH       (W),
      .SYNC_STAGES (SS),
      .OUT_INVERT  (1'b1),
      .OUT_RESET   ({24'h0, OUT_RST})
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .i_adr   (i_adr),
      .i_dat   (i_dat),
      .i_sel   (i_sel),
      .i_we    (i_we),
      .i_cyc   (i_cyc),
      .o_rdt   (o_rdt),
      .o_ack   (o_ack),
      .gpio_i  (gpio_i),
      .gpio_o  (gpio_o),
      .gpio_oe (gpio_oe),
      .o_irq   (o_irq)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Registers as plain values; pins[k] is the pad sample taken k edges ago.
   logic          m_ack;
   logic [31:0]   m_rdt;
   logic [7:0]    m_out, m_dir, m_en, m_stat, m_edge;
   logic          m_irq;
   logic [7:0]    pins[0:SS];
   logic          acc;
   logic [7:0]    in_now, in_prev, lanes, msk, hits, w1c;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_ack = 1'b0; m_rdt = '0; m_out = OUT_RST; m_dir = '0;
         m_en = '0; m_stat = '0; m_edge = '0; m_irq = 1'b0;
         for (int i = 0; i <= SS; i++) pins[i] = '0;
      end else begin
         acc     = i_cyc && !m_ack;
         in_now  = pins[SS-1];
         in_prev = pins[SS];
         for (int b = 0; b < W; b++) lanes[b] = i_sel[b/8];
         msk     = i_dat[7:0] & lanes;
         hits    = m_en & ((in_now & ~in_prev & ~m_edge) | (~in_now & in_prev & m_edge));
         w1c     = '0;
         m_rdt   = '0;
         if (acc && !i_we) begin
            case (i_adr[5:2])
               4'd0: m_rdt = {24'h0, m_out};
               4'd1: m_rdt = {24'h0, m_dir};
               4'd2: m_rdt = {24'h0, in_now};
`ifdef GPIO_IRQ_EN
               4'd6: m_rdt = {24'h0, m_en};
               4'd7: m_rdt = {24'h0, m_stat};
               4'd8: m_rdt = {24'h0, m_edge};
`endif
               default: m_rdt = '0;
            endcase
         end
         if (acc && i_we) begin
            case (i_adr[5:2])
               4'd0: m_out = (m_out & ~lanes) | msk;
               4'd1: m_dir = (m_dir & ~lanes) | msk;
               4'd3: m_out = m_out | msk;
               4'd4: m_out = m_out & ~msk;
               4'd5: m_out = m_out ^ msk;
`ifdef GPIO_IRQ_EN
               4'd6: m_en   = (m_en & ~lanes) | msk;
               4'd7: w1c    = msk;
               4'd8: m_edge = (m_edge & ~lanes) | msk;
`endif
               default: ;
            endcase
         end
         m_stat = (m_stat & ~w1c) | hits;
         m_irq  = |(m_stat & m_en);
         m_ack  = acc;
         for (int i = SS; i > 0; i--) pins[i] = pins[i-1];
         pins[0] = gpio_i;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("cyc_ack",    {31'h0, o_ack},   {31'h0, m_ack});
      chk("cyc_rdt",    o_rdt,            m_rdt);
      chk("cyc_gpio_o", {24'h0, gpio_o},  {24'h0, ~m_out});
      chk("cyc_oe",     {24'h0, gpio_oe}, {24'h0, m_dir});
      chk("cyc_irq",    {31'h0, o_irq},   {31'h0, m_irq});
   end

   // ---------------- drivers ----------------
   task automatic bus_xfer(input logic [5:0] off, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata);
      logic got;
      got   = 1'b0;
      rdata = '0;
      @(posedge clk); #2;
      i_adr = 32'h4000_0000 | {26'h0, off} | 32'h3;
      i_dat = dat; i_sel = sel; i_we = we; i_cyc = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (o_ack) begin
            got   = 1'b1;
            rdata = o_rdt;
            break;
         end
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL ack_timeout: no ack for offset %h", off);
      end
      @(posedge clk); #2;
      i_cyc = 1'b0; i_we = 1'b0;
      @(negedge clk);
      chk("ack_one_cycle", {31'h0, o_ack}, 32'h0);
   endtask

   task automatic bus_write(input logic [5:0] off, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] dummy;
      bus_xfer(off, 1'b1, dat, sel, dummy);
   endtask

   task automatic read_expect(input string name, input logic [5:0] off, input logic [31:0] exp);
      logic [31:0] rd;
      exp_q.push_back(exp);
      bus_xfer(off, 1'b0, 32'h0, 4'hF, rd);
      chk(name, rd, exp_q.pop_front());
   endtask

   // ---------------- directed sequence ----------------
   int acks;

   initial begin
      resetn = 1'b0; i_adr = '0; i_dat = '0; i_sel = '0; i_we = 1'b0; i_cyc = 1'b0;
      gpio_i = '0;
      repeat (2) @(posedge clk); #2;
      resetn = 1'b1;

      // reset values
      @(negedge clk);
      chk("rst_gpio_o", {24'h0, gpio_o}, 32'h5A);
      chk("rst_oe",     {24'h0, gpio_oe}, 32'h0);
      chk("rst_ack",    {31'h0, o_ack}, 32'h0);
      chk("rst_rdt",    o_rdt, 32'h0);
      chk("rst_irq",    {31'h0, o_irq}, 32'h0);

      // plain write/read and back-to-back reads
      bus_write(6'h00, 32'h0000_00F0, 4'hF);
      read_expect("rd_out_f0", 6'h00, 32'hF0);
      chk("gpio_o_f0", {24'h0, gpio_o}, 32'h0F);
      @(posedge clk); #2;
      i_adr = 32'h0; i_we = 1'b0; i_sel = 4'hF; i_cyc = 1'b1;
      acks = 0;
      repeat (6) begin
         @(negedge clk);
         if (o_ack) begin
            acks++;
            chk("b2b_rdt", o_rdt, 32'hF0);
         end
      end
      @(posedge clk); #2;
      i_cyc = 1'b0;
      chk("b2b_ack_count", acks, 32'd3);

      // atomic ops, byte lanes, direction
      bus_write(6'h0C, 32'h0000_000F, 4'hF);
      read_expect("set_ff", 6'h00, 32'hFF);
      bus_write(6'h10, 32'h0000_0081, 4'hF);
      read_expect("clr_7e", 6'h00, 32'h7E);
      bus_write(6'h14, 32'h0000_00FF, 4'hF);
      read_expect("tgl_81", 6'h00, 32'h81);
      bus_write(6'h00, 32'h1234_5678, 4'b0001);
      read_expect("lane_78", 6'h00, 32'h78);
      bus_write(6'h00, 32'hFFFF_FF00, 4'b1110);
      read_expect("lane_masked", 6'h00, 32'h78);
      bus_write(6'h00, 32'h0000_0055, 4'h0);
      read_expect("sel0_noeffect", 6'h00, 32'h78);
      bus_write(6'h04, 32'h0000_000F, 4'hF);
      read_expect("dir_0f", 6'h04, 32'h0F);
      chk("oe_0f", {24'h0, gpio_oe}, 32'h0F);
      read_expect("rd_set_zero", 6'h0C, 32'h0);

      // input synchroniser latency
      @(posedge clk); #2;
      gpio_i = 8'h3C;
      read_expect("in_early", 6'h08, 32'h0);
      read_expect("in_3c", 6'h08, 32'h3C);
      read_expect("unmapped_3c", 6'h3C, 32'h0);
      bus_write(6'h3C, 32'hFFFF_FFFF, 4'hF);
      read_expect("out_after_unmapped", 6'h00, 32'h78);
      gpio_i = 8'h00;
      repeat (4) @(posedge clk);

`ifdef GPIO_IRQ_EN
      bus_write(6'h18, 32'h1, 4'hF);
      bus_write(6'h20, 32'h0, 4'hF);
      @(posedge clk); #2;
      gpio_i = 8'h01;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("irq_rise", {31'h0, o_irq}, 32'h1);
      read_expect("stat_01", 6'h1C, 32'h1);
      @(posedge clk); #2;
      gpio_i = 8'h00;
      repeat (4) @(posedge clk);
      #2;
      gpio_i = 8'h01;
      @(posedge clk);
      bus_write(6'h1C, 32'h1, 4'hF);
      read_expect("stat_edge_wins", 6'h1C, 32'h1);
      chk("irq_still", {31'h0, o_irq}, 32'h1);
      bus_write(6'h1C, 32'h1, 4'hF);
      read_expect("stat_cleared", 6'h1C, 32'h0);
      chk("irq_cleared", {31'h0, o_irq}, 32'h0);
      bus_write(6'h20, 32'h1, 4'hF);
      @(posedge clk); #2;
      gpio_i = 8'h00;
      repeat (4) @(posedge clk);
      read_expect("stat_fall", 6'h1C, 32'h1);
      bus_write(6'h1C, 32'h1, 4'hF);
`else
      read_expect("noirq_0x18", 6'h18, 32'h0);
      read_expect("noirq_0x1c", 6'h1C, 32'h0);
      chk("noirq_tied", {31'h0, o_irq}, 32'h0);
`endif

      // reset in the middle of an access
      @(posedge clk); #2;
      i_adr = 32'h0; i_dat = 32'h55; i_sel = 4'hF; i_we = 1'b1; i_cyc = 1'b1;
      #1 resetn = 1'b0;
      @(negedge clk);
      chk("rst_mid_ack", {31'h0, o_ack}, 32'h0);
      repeat (2) @(posedge clk); #2;
      i_cyc = 1'b0; i_we = 1'b0;
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_mid_ack2", {31'h0, o_ack}, 32'h0);
      read_expect("out_after_lost", 6'h00, {24'h0, OUT_RST});
      bus_write(6'h00, 32'h55, 4'hF);
      read_expect("out_retry", 6'h00, 32'h55);

      repeat (2) @(posedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
